psum_adder_pipe: RTL
====================

// Module: psum_adder_pipe
// PURPOSE
//  Pipelined, parametrised successor of the conv-engine adder. Reduces N_IN signed
//  products, then optionally adds partial sum, bias and ReLU, per mode. Sits between
//  the PE multiplier array and the psum buffer; valid/ready on both sides.
//  Adds saturation, stall handling and a sticky overflow flag.
// PARAMETERS
//  DATA_BITS      16  width of bias (signed)
//  INTERNAL_BITS  32  width of data_in lanes, psum and result (signed)
//  N_IN           3   number of data_in lanes summed (>=1)
//  SAT_EN         1   1: clamp result to INTERNAL_BITS signed range; 0: wrap (truncate)
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    synchronous reset, active-high
//  in_valid   in   1                    input beat valid
//  in_ready   out  1                    block accepts beat this cycle
//  data_in    in   N_IN*INTERNAL_BITS   lane i = bits [i*IB +: IB], signed
//  psum       in   INTERNAL_BITS        partial sum, signed
//  bias       in   DATA_BITS            bias, signed; sign-extended
//  mode       in   2                    0 SUM, 1 +PSUM, 2 +PSUM+BIAS, 3 +PSUM+BIAS then ReLU
//  out_valid  out  1                    result valid
//  out_ready  in   1                    downstream accepts result
//  result     out  INTERNAL_BITS        signed result
//  ovf_flag   out  1                    sticky: set when any result saturated/wrapped
//  ovf_clr    in   1                    clears ovf_flag
// BEHAVIOUR
//  - One clock (clk), synchronous active-high reset rst; no async logic.
//  - Beat accepted when in_valid && in_ready; psum/bias/mode sampled with data_in.
//  - Stage S1 registers: tree sum of lanes (ACC_BITS = INTERNAL_BITS+clog2(N_IN+2)),
//    psum, sext(bias), mode. Stage S2 registers final result.
//  - Mode 0 ignores psum and bias; mode 1 ignores bias; mode 3 forces negative to 0
//    after saturation/wrap.
//  - Width: all adds done in ACC_BITS, no intermediate overflow. Final narrow to
//    INTERNAL_BITS: SAT_EN=1 clamps to [-2^(IB-1), 2^(IB-1)-1]; SAT_EN=0 keeps low bits.
//    Either way, ovf event = ACC value outside IB range.
//  - Latency: 2 cycles accept->out_valid when out_ready held high; throughput 1/cycle.
//  - Flow: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//    Combinational in_ready from out_ready is permitted; no other comb paths in->out.
//  - Stall: while out_valid && !out_ready, result and out_valid held stable; no beat lost
//    or duplicated; S1 fills, then in_ready drops.
//  - ovf_flag set on the cycle an ovf beat enters S2. ovf_clr clears it next cycle.
//    Simultaneous set and clr: set wins.
//  - Reset: s1_valid=s2_valid=0, out_valid=0, in_ready=1 after reset deasserts,
//    result=0, ovf_flag=0. Reset mid-stream drops in-flight beats; the first beat after
//    reset has latency 2.
//  - in_valid during rst is ignored.
// STRUCTURE
//  - Shared package cnn_pkg: MODE_SUM/MODE_PSUM/MODE_BIAS/MODE_RELU localparams,
//    clog2 helper; DATA_BITS/INTERNAL_BITS defaults come from the shared defines.
//  - One sub-module: adder_tree (combinational, params N_IN, IN_BITS, OUT_BITS),
//    signed reduction of lanes; used by S1.
//  - Top holds both pipeline stages, narrowing/ReLU logic and the flag.
// TESTING
//  - Mode sweep: lanes {5,-3,10}, psum 100, bias -7 -> results 12, 112, 105, 105 (mode 3),
//    each 2 cycles after accept.
//  - ReLU: lanes {-50,0,0}, psum 10, bias 0, mode 3 -> 0; same beat mode 2 -> -40.
//  - Saturation: SAT_EN=1, lanes all 0x7FFF_FFFF, mode 0 -> 0x7FFF_FFFF, ovf_flag=1;
//    SAT_EN=0 -> 0x7FFF_FFFD, ovf_flag=1. ovf_clr pulse -> 0 next cycle.
//    Clr on same cycle as new ovf -> flag stays 1.
//  - Backpressure: 8 back-to-back beats, out_ready low for cycles 3-6 -> in_ready low
//    after 2 held beats; all 8 results emitted in order, none duplicated.
//  - Reset mid-stream: rst during 2 in-flight beats -> out_valid 0, result 0, ovf_flag 0
//    next cycle; next beat emerges after 2 cycles.
//  - Bias sign-ext: bias 16'h8000, mode 2, others 0 -> result -32768.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared conv-engine definitions: default datapath widths, adder modes and a
// constant-time ceil(log2) helper for width arithmetic.
package cnn_pkg;

  localparam int DEF_DATA_BITS     = 16;
  localparam int DEF_INTERNAL_BITS = 32;

  localparam logic [1:0] MODE_SUM  = 2'd0;
  localparam logic [1:0] MODE_PSUM = 2'd1;
  localparam logic [1:0] MODE_BIAS = 2'd2;
  localparam logic [1:0] MODE_RELU = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_adder_pipe_adder_tree.sv
// Combinational signed reduction of N_IN packed lanes into a wider sum that
// cannot overflow for the chosen OUT_BITS.
module adder_tree #(
  parameter int N_IN     = 3,
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 35
) (
  input  logic [N_IN*IN_BITS-1:0]  lanes,
  output logic signed [OUT_BITS-1:0] sum
);

  logic signed [IN_BITS-1:0] lane;

  always_comb begin
    sum  = '0;
    lane = '0;
    for (int i = 0; i < N_IN; i++) begin
      lane = lanes[i*IB_OFS(i) +: IN_BITS];
      sum  = sum + OUT_BITS'(lane);
    end
  end

  function automatic int IB_OFS(input int idx);
    return (idx >= 0) ? IN_BITS : IN_BITS;
  endfunction

endmodule

// File: rtl/psum_adder_pipe.sv
// Two-stage psum adder: S1 registers the lane sum and operands, S2 registers the
// narrowed (saturated or wrapped), optionally ReLU'd result. Valid/ready both sides.
module psum_adder_pipe
  import cnn_pkg::*;
#(
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int INTERNAL_BITS = DEF_INTERNAL_BITS,
  parameter int N_IN          = 3,
  parameter int SAT_EN        = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*INTERNAL_BITS-1:0]   data_in,
  input  logic signed [INTERNAL_BITS-1:0] psum,
  input  logic signed [DATA_BITS-1:0]     bias,
  input  logic [1:0]                      mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [INTERNAL_BITS-1:0] result,
  output logic                            ovf_flag,
  input  logic                            ovf_clr
);

  localparam int IB       = INTERNAL_BITS;
  localparam int ACC_BITS = IB + clog2(N_IN + 2);

  localparam logic signed [ACC_BITS-1:0] MAX_V = {{(ACC_BITS-IB+1){1'b0}}, {(IB-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] MIN_V = {{(ACC_BITS-IB+1){1'b1}}, {(IB-1){1'b0}}};

  function automatic logic out_of_range(input logic signed [ACC_BITS-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic signed [IB-1:0] narrow(input logic signed [ACC_BITS-1:0] v);
    if (SAT_EN != 0 && v > MAX_V) return MAX_V[IB-1:0];
    if (SAT_EN != 0 && v < MIN_V) return MIN_V[IB-1:0];
    return v[IB-1:0];
  endfunction

  function automatic logic signed [IB-1:0] relu(input logic signed [IB-1:0] v);
    return v[IB-1] ? '0 : v;
  endfunction

  logic                       s1_adv, s2_adv;
  logic signed [ACC_BITS-1:0] tree_sum;

  logic signed [ACC_BITS-1:0] sum_p1, psum_p1, bias_p1;
  logic [1:0]                 mode_p1;
  logic                       vld_p1;

  logic signed [ACC_BITS-1:0] acc_p1;
  logic signed [IB-1:0]       narrow_p1, final_p1;
  logic                       ovf_p1;

  logic signed [IB-1:0]       result_p2;
  logic                       vld_p2;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  adder_tree #(
    .N_IN    (N_IN),
    .IN_BITS (IB),
    .OUT_BITS(ACC_BITS)
  ) u_tree (
    .lanes(data_in),
    .sum  (tree_sum)
  );

  // ---- S0 -> S1: lane sum and operands captured on accept
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv) begin
      sum_p1  <= tree_sum;
      psum_p1 <= ACC_BITS'(psum);
      bias_p1 <= ACC_BITS'(bias);
      mode_p1 <= mode;
    end
  end

  always_comb begin
    acc_p1 = sum_p1;
    if (mode_p1 != MODE_SUM) acc_p1 = acc_p1 + psum_p1;
    if (mode_p1 == MODE_BIAS || mode_p1 == MODE_RELU) acc_p1 = acc_p1 + bias_p1;
    ovf_p1    = out_of_range(acc_p1);
    narrow_p1 = narrow(acc_p1);
    final_p1  = (mode_p1 == MODE_RELU) ? relu(narrow_p1) : narrow_p1;
  end

  // ---- S1 -> S2: final result and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) result_p2 <= final_p1;
      end
      // A new overflow beat outranks a simultaneous clear.
      if (s2_adv && vld_p1 && ovf_p1) ovf_flag <= 1'b1;
      else if (ovf_clr)               ovf_flag <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;

endmodule
